fft_reorder: RTL

- Consumer-side companion of the streaming radix-2^2 SDF FFT pipeline. It takes the FFT output stream, which arrives in bit-reversed bin order, and re-emits each frame in natural bin order (bin 0 first).
- Uses a ping-pong pair of N-entry buffers, so one frame is written while the previous one is read out.
- Sits between the FFT and the spectral feature stages of the speech front end.

---
 rtl/fft_reorder_if.sv | 28 ++
 rtl/fft_reorder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fft_reorder_if.sv
`default_nettype none
// =============================================================================
// fft_reorder_if : FFT output stream in (bit-reversed), natural-order stream out
// Rev 1.0
// =============================================================================
interface fft_reorder_if #(
    parameter int WIDTH = 16
);
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_last;
    logic             di_abort;

    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im, do_last, di_abort
    );

    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im, do_last, di_abort
    );
endinterface
`default_nettype wire

// File: rtl/fft_reorder.sv
`default_nettype none
// =============================================================================
// fft_reorder : ping-pong reorder of bit-reversed FFT frames to natural bin order
// Option macro FFT_REORDER_HALF_EN : emit bins 0..N/2-1 only.   Rev 1.0
// =============================================================================
module fft_reorder #(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    fft_reorder_if.slave     bus
);

    localparam int            AW      = $clog2(N);
    localparam logic [AW-1:0] LAST_WR = AW'(N - 1);
`ifdef FFT_REORDER_HALF_EN
    localparam logic [AW-1:0] LAST_RD = AW'(N / 2 - 1);
`else
    localparam logic [AW-1:0] LAST_RD = AW'(N - 1);
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   wcnt;
    logic [AW-1:0]   raddr, raddr_next;
    logic            wbank;
    logic            rbank, rbank_next;
    logic            frame_done;
    logic            read_end;
    logic [2*WIDTH-1:0] mem [0:2*N-1];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    assign frame_done = bus.di_en && (wcnt == LAST_WR);
    assign read_end   = (state == READ) && (raddr == LAST_RD);

    // Write side: a drop of di_en mid-frame discards the partial frame in place.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wcnt         <= '0;
            wbank        <= 1'b0;
            bus.di_abort <= 1'b0;
        end else begin
            bus.di_abort <= !bus.di_en && (wcnt != '0);
            if (bus.di_en) begin
                wcnt <= wcnt + AW'(1);
                if (frame_done) begin
                    wbank <= ~wbank;
                end
            end else begin
                wcnt <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (bus.di_en) begin
            mem[{wbank, bitrev(wcnt)}] <= {bus.di_re, bus.di_im};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            raddr <= '0;
            rbank <= 1'b0;
        end else begin
            state <= state_next;
            raddr <= raddr_next;
            rbank <= rbank_next;
        end
    end

    // The bank being read is the one that just filled, i.e. wbank before it toggles.
    always_comb begin
        state_next = state;
        raddr_next = raddr;
        rbank_next = rbank;
        case (state)
            IDLE: begin
                if (frame_done) begin
                    state_next = READ;
                    raddr_next = '0;
                    rbank_next = wbank;
                end
            end
            READ: begin
                if (read_end) begin
                    raddr_next = '0;
                    if (frame_done) begin
                        rbank_next = wbank;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    raddr_next = raddr + AW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Synchronous memory read lands directly in the output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.do_en   <= 1'b0;
            bus.do_last <= 1'b0;
            bus.do_re   <= '0;
            bus.do_im   <= '0;
        end else begin
            bus.do_en   <= (state == READ);
            bus.do_last <= read_end;
            if (state == READ) begin
                {bus.do_re, bus.do_im} <= mem[{rbank, raddr}];
            end
        end
    end

endmodule
`default_nettype wire
